// File: rtl/traffic_pkg.sv
// traffic_pkg: lamp and phase types plus lamp decode helpers for traffic_phase_scheduler.
package traffic_pkg;

    typedef enum logic [1:0] {GREEN = 2'b00, YELLOW = 2'b01, RED = 2'b10} light_t;

    typedef enum logic [2:0] {
        A_GREEN, A_YELLOW, ALLRED_AB, B_GREEN, B_YELLOW, ALLRED_BA
    } phase_t;

    function automatic light_t la_of(phase_t p);
        if (p == A_GREEN) return GREEN;
        if (p == A_YELLOW) return YELLOW;
        return RED;
    endfunction

    function automatic light_t lb_of(phase_t p);
        if (p == B_GREEN) return GREEN;
        if (p == B_YELLOW) return YELLOW;
        return RED;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// phase_timer: cycles-in-phase counter with clear and saturation, plus green compare flags.
module phase_timer #(
    parameter int WIDTH = 6,
    parameter int MIN_T = 7,
    parameter int SAT   = 31
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_t,
    output logic             o_ge_min,
    output logic             o_at_max
);

    logic [WIDTH-1:0] r_t;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_t <= '0;
        else     r_t <= i_clr ? '0 : (o_at_max ? r_t : r_t + 1'b1);
    end

    assign o_t      = r_t;
    assign o_ge_min = r_t >= WIDTH'(MIN_T);
    assign o_at_max = r_t == WIDTH'(SAT);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: two-street green/yellow/all-red sequencer with sensor-extended green.
// Emergency preemption is built only when TRAFFIC_PREEMPT_EN is defined.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN  = 8,
    parameter int MAX_GREEN  = 32,
    parameter int YELLOW_CYC = 4,
    parameter int ALLRED_CYC = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       TA,
    input  logic       TB,
    input  logic       preempt_req,
    input  logic       preempt_dir,
    output logic [1:0] LA,
    output logic [1:0] LB,
    output logic [2:0] phase,
    output logic       preempt_ack
);

    localparam int W = $clog2(MAX_GREEN + 1);
    localparam logic PRE_EN =
`ifdef TRAFFIC_PREEMPT_EN
        1'b1;
`else
        1'b0;
`endif

    phase_t         r_phase;
    phase_t         w_next;
    logic [W-1:0]   w_t;
    logic           w_ge_min;
    logic           w_at_max;
    logic           w_hold_a;
    logic           w_hold_b;

    assign w_hold_a = PRE_EN && preempt_req && !preempt_dir;
    assign w_hold_b = PRE_EN && preempt_req && preempt_dir;

    phase_timer #(.WIDTH(W), .MIN_T(MIN_GREEN - 1), .SAT(MAX_GREEN - 1)) u_timer (
        .clk      (clk),
        .rst      (reset),
        .i_clr    (w_next != r_phase),
        .o_t      (w_t),
        .o_ge_min (w_ge_min),
        .o_at_max (w_at_max)
    );

    // A hold request for the served street overrides both its sensor and MAX_GREEN.
    always_comb begin
        w_next = r_phase;
        case (r_phase)
            A_GREEN:   if (w_hold_b || (!w_hold_a && ((w_ge_min && !TA) || w_at_max))) w_next = A_YELLOW;
            A_YELLOW:  if (w_t == W'(YELLOW_CYC - 1)) w_next = ALLRED_AB;
            ALLRED_AB: if (w_t == W'(ALLRED_CYC - 1)) w_next = w_hold_a ? A_GREEN : B_GREEN;
            B_GREEN:   if (w_hold_a || (!w_hold_b && ((w_ge_min && !TB) || w_at_max))) w_next = B_YELLOW;
            B_YELLOW:  if (w_t == W'(YELLOW_CYC - 1)) w_next = ALLRED_BA;
            ALLRED_BA: if (w_t == W'(ALLRED_CYC - 1)) w_next = w_hold_b ? B_GREEN : A_GREEN;
            default:   w_next = A_GREEN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_phase <= A_GREEN;
        else       r_phase <= w_next;
    end

    assign phase       = r_phase;
    assign LA          = la_of(r_phase);
    assign LB          = lb_of(r_phase);
    assign preempt_ack = (w_hold_a && r_phase == A_GREEN) || (w_hold_b && r_phase == B_GREEN);

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb_traffic_phase_scheduler: directed plus randomized checks against a cycle-count reference model.
module tb_traffic_phase_scheduler;

    localparam int MIN_G = 4, MAX_G = 10, YEL = 2, AR = 1;
    localparam bit PRE_EN =
`ifdef TRAFFIC_PREEMPT_EN
        1'b1;
`else
        1'b0;
`endif

    logic clk = 1'b0, reset = 1'b1;
    logic TA = 1'b0, TB = 1'b0, preempt_req = 1'b0, preempt_dir = 1'b0;
    logic [1:0] LA, LB;
    logic [2:0] phase;
    logic preempt_ack;

    int n_chk = 0, n_pass = 0;
    int m_p = 0, m_c = 0;
    int la_tab [6] = '{0, 1, 2, 2, 2, 2};
    int lb_tab [6] = '{2, 2, 2, 0, 1, 2};
    bit last_ack;

    traffic_phase_scheduler #(.MIN_GREEN(MIN_G), .MAX_GREEN(MAX_G), .YELLOW_CYC(YEL), .ALLRED_CYC(AR)) dut (
        .clk(clk), .reset(reset), .TA(TA), .TB(TB), .preempt_req(preempt_req), .preempt_dir(preempt_dir),
        .LA(LA), .LB(LB), .phase(phase), .preempt_ack(preempt_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Model: phase index plus cycles already spent there; green length rules stated in whole cycles.
    task automatic model_step(input bit ta, input bit tb, input bit req, input bit dir);
        bit pre = PRE_EN && req;
        bit leave;
        bit is_green = (m_p == 0 || m_p == 3);
        bit mine = (m_p == 0) ? !dir : dir;
        bit sensor = (m_p == 0) ? ta : tb;
        int lasted = m_c + 1;
        if (is_green)
            leave = pre ? !mine : ((lasted >= MIN_G && !sensor) || lasted >= MAX_G);
        else
            leave = lasted >= ((m_p == 1 || m_p == 4) ? YEL : AR);
        if (leave) begin
            if ((m_p == 2 && pre && !dir) || (m_p == 5 && pre && dir)) m_p = m_p - 2;
            else m_p = (m_p + 1) % 6;
            m_c = 0;
        end else m_c++;
    endtask

    task automatic cyc(input bit ta, input bit tb, input bit req, input bit dir);
        bit exp_ack;
        TA = ta; TB = tb; preempt_req = req; preempt_dir = dir;
        #1;
        exp_ack = PRE_EN && req && ((m_p == 0 && !dir) || (m_p == 3 && dir));
        check("phase", int'(phase), m_p);
        check("LA", int'(LA), la_tab[m_p]);
        check("LB", int'(LB), lb_tab[m_p]);
        check("ack", int'(preempt_ack), int'(exp_ack));
        last_ack = preempt_ack;
        @(posedge clk);
        model_step(ta, tb, req, dir);
        @(negedge clk);
    endtask

    task automatic do_reset();
        TA = 0; TB = 0; preempt_req = 0; preempt_dir = 0;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        m_p = 0; m_c = 0;
    endtask

    initial begin
        int n;
        bit rq, dr;
        @(negedge clk);
        #1;
        check("rst_phase", int'(phase), 0);
        check("rst_LA", int'(LA), 0);
        check("rst_LB", int'(LB), 2);
        check("rst_ack", int'(preempt_ack), 0);
        reset = 1'b0;

        n = 0;
        for (int k = 0; k < 40 && phase == 0; k++) begin cyc(0, 0, 0, 0); n++; end
        check("t2_agreen_len", n, MIN_G);
        for (int k = 0; k < 30; k++) cyc(0, 0, 0, 0);

        for (int k = 0; k < 40 && !(m_p == 3 && m_c == 1); k++) cyc(0, 0, 0, 0);
        #2 reset = 1'b1;
        #1;
        check("t1_async_phase", int'(phase), 0);
        check("t1_async_LA", int'(LA), 0);
        check("t1_async_LB", int'(LB), 2);
        check("t1_async_ack", int'(preempt_ack), 0);
        reset = 1'b0;
        m_p = 0; m_c = 0;
        @(negedge clk);

        do_reset();
        n = 0;
        for (int k = 0; k < 40 && phase == 0; k++) begin cyc(1, 0, 0, 0); n++; end
        check("t3_max_len", n, MAX_G);

        do_reset();
        n = 0;
        for (int k = 0; k < 40 && phase == 0; k++) begin cyc(k < 6, 0, 0, 0); n++; end
        check("t4_release_len", n, 7);

        do_reset();
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 1);
        check("t5_yellow", int'(phase), PRE_EN ? 1 : 0);
        for (int k = 0; k < 3; k++) cyc(0, 0, 1, 1);
        check("t5_bgreen", int'(phase), PRE_EN ? 3 : 1);
        n = 0;
        for (int k = 0; k < 20; k++) begin cyc(0, 0, 1, 1); n += int'(last_ack); end
        check("t5_ack_cycles", n, PRE_EN ? 20 : 0);
        cyc(0, 0, 0, 1);
        check("t5_release", int'(phase), 4);

        do_reset();
        for (int k = 0; k < 20 && m_p != 2; k++) cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        check("t6_phase", int'(phase), PRE_EN ? 0 : 3);
        #1;
        check("t6_ack", int'(preempt_ack), int'(PRE_EN));
        @(negedge clk);
        cyc(0, 0, 0, 0);

        rq = 0; dr = 0;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 24) == 0) begin rq = !rq; dr = 1'($urandom_range(0, 1)); end
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, rq, dr);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
